// File: rtl/eth10g_tx_arb_pkg.sv
// Shared types, state codes and the round-robin pick rule for the 10G TX frame arbiter.
package eth10g_tx_arb_pkg;

  localparam int ETH_MAX_FRAME_BEATS = 190;
  localparam int RR_MAX_REQ          = 8;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_XFER  = 2'd1;
  localparam arb_state_t ST_DRAIN = 2'd2;
  localparam arb_state_t ST_GAP   = 2'd3;

  // First eligible index searching upward from last_grant+1, wrapping at num_req.
  // Returns last_grant when nothing is eligible.
  function automatic logic [2:0] rr_pick(input logic [RR_MAX_REQ-1:0] eligible,
                                         input logic [2:0]            last_grant,
                                         input int                    num_req);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = last_grant;
    found = 1'b0;
    for (int i = 1; i <= RR_MAX_REQ; i++) begin
      idx = (int'(last_grant) + i) % num_req;
      if ((i <= num_req) && !found && eligible[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/eth10g_rr_arbiter.sv
// Round-robin selector: combinational pick from the registered last-grant pointer,
// pointer advances to the pick when i_load is high and something is eligible.
module eth10g_rr_arbiter
  import eth10g_tx_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic               i_load,
  output logic               o_any,
  output logic [ID_W-1:0]    o_ptr
);

  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       w_pick;
  logic [RR_MAX_REQ-1:0] w_elig8;

  assign w_elig8 = RR_MAX_REQ'(i_eligible);
  assign w_pick  = ID_W'(rr_pick(w_elig8, 3'(r_ptr), NUM_REQ));
  assign o_any   = |i_eligible;
  assign o_ptr   = r_ptr;

  // Reset to the top index so requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= ID_W'(NUM_REQ - 1);
    end else if (i_load && o_any) begin
      r_ptr <= w_pick;
    end
  end

endmodule

// File: rtl/eth10g_tx_frame_arbiter.sv
// Frame-granular round-robin mux of NUM_REQ TX streams onto one 10G MAC input,
// with a forced inter-packet gap and truncation of frames longer than MAX_BEATS.
module eth10g_tx_frame_arbiter
  import eth10g_tx_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 64,
  parameter  int IPG_CYC   = 2,
  parameter  int MAX_BEATS = ETH_MAX_FRAME_BEATS,
  localparam int KEEP_W    = DATA_W / 8,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ*KEEP_W-1:0]  req_keep,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [KEEP_W-1:0]          out_keep,
  output logic                       out_last,
  output logic                       out_err,
  input  logic                       out_ready,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy,
  output logic [15:0]                trunc_cnt,
  output arb_state_t                 dbg_state
);

  localparam int         CNT_W    = $clog2(MAX_BEATS + 1);
  localparam int         GAP_W    = (IPG_CYC > 1) ? $clog2(IPG_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'((IPG_CYC > 0) ? IPG_CYC - 1 : 0);
  localparam arb_state_t ST_AFTER = (IPG_CYC == 0) ? ST_IDLE : ST_GAP;

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [15:0]      r_trunc_cnt;

  logic [NUM_REQ-1:0] w_eligible;
  logic               w_any;
  logic [ID_W-1:0]    w_gid;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic [DATA_W-1:0]  w_sel_data;
  logic [KEEP_W-1:0]  w_sel_keep;
  logic               w_trunc_beat;
  logic               w_xfer_acc;
  logic               w_drain_acc;

  assign w_eligible = req_valid & req_en;

  eth10g_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk        (clk),
    .rst        (rst),
    .i_eligible (w_eligible),
    .i_load     (r_state == ST_IDLE),
    .o_any      (w_any),
    .o_ptr      (w_gid)
  );

  assign w_sel_valid = req_valid[w_gid];
  assign w_sel_last  = req_last[w_gid];
  assign w_sel_data  = req_data[w_gid*DATA_W +: DATA_W];
  assign w_sel_keep  = req_keep[w_gid*KEEP_W +: KEEP_W];

  // Handshake: a beat moves on a clock edge where valid and ready are both high;
  // ready never depends on anything but state, grant and out_ready.
  assign w_xfer_acc   = (r_state == ST_XFER) && w_sel_valid && out_ready;
  assign w_drain_acc  = (r_state == ST_DRAIN) && w_sel_valid;
  assign w_trunc_beat = (r_state == ST_XFER) && w_sel_valid && !w_sel_last &&
                        (r_beat_cnt == LAST_CNT);

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_keep  = '0;
    out_last  = 1'b0;
    out_err   = 1'b0;
    req_ready = '0;
    case (r_state)
      ST_XFER: begin
        out_valid        = w_sel_valid;
        out_data         = w_sel_data;
        out_keep         = w_sel_keep;
        out_last         = w_sel_last | w_trunc_beat;
        out_err          = w_trunc_beat;
        req_ready[w_gid] = out_ready;
      end
      ST_DRAIN: req_ready[w_gid] = 1'b1;
      default: ;
    endcase
  end

  assign grant_id  = w_gid;
  assign busy      = (r_state != ST_IDLE);
  assign trunc_cnt = r_trunc_cnt;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_beat_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_trunc_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state    <= ST_XFER;
            r_beat_cnt <= '0;
          end
        end
        ST_XFER: begin
          if (w_xfer_acc) begin
            if (w_sel_last) begin
              r_state   <= ST_AFTER;
              r_gap_cnt <= '0;
            end else if (r_beat_cnt == LAST_CNT) begin
              r_state <= ST_DRAIN;
              if (r_trunc_cnt != 16'hFFFF) r_trunc_cnt <= r_trunc_cnt + 16'd1;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_drain_acc && w_sel_last) begin
            r_state   <= ST_AFTER;
            r_gap_cnt <= '0;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_END) r_state <= ST_IDLE;
          else                      r_gap_cnt <= r_gap_cnt + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/eth10g_tx_frame_arbiter.md
Name: eth10g_tx_frame_arbiter

Overview:
- Round-robin scheduler that shares the single 64-bit 10G Ethernet MAC transmit datapath (ETH_10G_IF side) between NUM_REQ frame sources.
- Grants whole frames, never interleaves beats, enforces a minimum inter-packet gap and truncates runaway frames.
- Sits between the per-source frame builders and the 10G MAC TX stream input.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 64, stream data width; keep width is DATA_W/8
- IPG_CYC, 2, idle clock cycles forced between consecutive frames (0 allowed)
- MAX_BEATS, 190, maximum beats per frame before truncation (1518 B at 8 B/beat)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- req_en  in  NUM_REQ  per-requester enable (config); sampled only at arbitration
- req_valid  in  NUM_REQ  beat valid per requester
- req_data  in  NUM_REQ*DATA_W  packed beat data, requester i at [i*DATA_W +: DATA_W]
- req_keep  in  NUM_REQ*DATA_W/8  packed byte enables
- req_last  in  NUM_REQ  final beat of frame
- req_ready  out  NUM_REQ  beat accept per requester
- out_valid  out  1  beat valid to MAC
- out_data  out  DATA_W  beat data
- out_keep  out  DATA_W/8  byte enables
- out_last  out  1  final beat
- out_err  out  1  qualifies out_last: frame truncated
- out_ready  in  1  MAC accept
- grant_id  out  $clog2(NUM_REQ)  current/last granted requester
- busy  out  1  high in any state except IDLE
- trunc_cnt  out  16  saturating count of truncated frames

Behaviour:
- Beat accepted when valid && ready on the same edge.
- States: IDLE, XFER, DRAIN, GAP.
- IDLE: eligible = req_valid & req_en. If nonzero, select the first eligible index searching from grant_id+1 modulo NUM_REQ, register it into grant_id, go to XFER. Arbitration latency: 1 cycle. No eligible requester: stay in IDLE.
- XFER datapath is combinational passthrough from requester g=grant_id:
  - out_valid=req_valid[g]; out_data/keep/last from g.
  - req_ready[g]=out_ready; all other req_ready=0.
- Beat counter: cleared on entry to XFER; increments per accepted beat.
- Accepted beat with last=1 ends the frame: go to GAP, or to IDLE if IPG_CYC==0.
- Truncation: accepted beat number MAX_BEATS (count==MAX_BEATS-1) without req_last:
  - out_last forced 1, out_err 1 on that beat; trunc_cnt+1 (saturates at 16'hFFFF); go to DRAIN.
  - Beat MAX_BEATS with req_last=1 is a legal frame with out_err=0.
- DRAIN: req_ready[g]=1, out_valid=0. Discard beats of g until its last beat is accepted, then go to GAP, or IDLE if IPG_CYC==0.
- GAP: out_valid=0, all req_ready=0 for exactly IPG_CYC cycles, then IDLE. The earliest next out_valid is IPG_CYC+1 cycles after the last-beat edge (IPG cycles plus the arbitration cycle).
- out_err=0 except on the truncating beat. Outside XFER: out_valid/out_last/out_err=0, out_data/out_keep=0.
- Deasserting req_en[g] mid-frame does not abort the frame. Deasserting req_valid[g] mid-frame holds the grant (bubble, no timeout).
- out_ready low: stall; all state and outputs hold.
- Reset values: state IDLE, grant_id=NUM_REQ-1 (requester 0 wins first), counters 0, trunc_cnt 0, busy 0, all outputs 0.
- Reset mid-frame: same values; the partial frame is abandoned, and the MAC is responsible for discarding it.

Decomposition:
- Package eth10g_tx_arb_pkg:
  - state enum (IDLE, XFER, DRAIN, GAP)
  - function rr_pick(eligible, last_grant) returning the next index
  - constant ETH_MAX_FRAME_BEATS=190
- Sub-module eth10g_rr_arbiter: pure round-robin selector, combinational pick plus registered pointer, reusable elsewhere.

Test Plan:
- Reset release; req 0 and req 2 both valid with 3-beat frames, IPG_CYC=2 -> grant 0 first; two idle cycles after its last; grant 2 on the next cycle after arbitration; out_err=0.
- All 4 valid continuously with 1-beat frames -> grant order 0,1,2,3,0; every frame separated by exactly 3 non-valid cycles (2 IPG + 1 arb).
- Req 1 sends a 200-beat frame with MAX_BEATS=190 -> beat 190 has out_last=1, out_err=1; beats 191..200 consumed with no out_valid; trunc_cnt=1.
- out_ready toggled 1,0,0,1 during a 4-beat frame -> output beats unaltered and in order; no beats dropped or duplicated; req_ready mirrors out_ready.
- req_en[1]=0 with req_valid[1]=1 and req 3 valid -> req 3 granted, req 1 never granted; clearing req_en[3] mid-frame still completes all beats.
- rst pulsed at beat 2 of a frame, then req 1 and req 0 valid -> outputs zero the cycle after reset; grant 0 first.
